// File: rtl/tetris_ctrl.sv
`default_nettype none
// ============================================================================
// tetris_ctrl : game sequencer driving the Tetris datapath state/move/strobes.
// Optional feature macro: LEVEL_SPEEDUP_EN (gravity interval shrinks with lines)
// Revision 1.0
// ============================================================================
module tetris_ctrl #(
  parameter int DROP_TICKS   = 16,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic       clka,
  input  logic       restart,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rotate,
  input  logic       touched,
  input  logic       error_out,
  input  logic [2:0] rows_cleared,
  output logic [2:0] state,
  output logic [1:0] move,
  output logic       piece_we,
  output logic       board_we,
  output logic [7:0] lines
);

  typedef enum logic [2:0] {
    ST_GEN      = 3'b000,
    ST_MOVE     = 3'b001,
    ST_LAND     = 3'b010,
    ST_CLEAR    = 3'b011,
    ST_NEWBOARD = 3'b100,
    ST_GAMEOVER = 3'b101
  } state_e;

  localparam logic [1:0] MV_LEFT    = 2'd0;
  localparam logic [1:0] MV_RIGHT   = 2'd1;
  localparam logic [1:0] MV_ROTATE  = 2'd2;
  localparam logic [1:0] MV_NONE    = 2'd3;
  localparam logic [3:0] CLEAR_LAST = 4'(CLEAR_CYCLES - 1);
  localparam logic [7:0] DROP_W     = 8'(DROP_TICKS);

  state_e     state_q, state_d;
  logic [1:0] move_q, move_d;
  logic       piece_we_q, piece_we_d;
  logic       board_we_q, board_we_d;
  logic [7:0] lines_q, lines_d;
  logic [7:0] grav_q, grav_d;
  logic [2:0] pend_q, pend_d;
  logic [2:0] btn_q;
  logic [3:0] phase_q, phase_d;

  logic [2:0] btn_now;
  logic [2:0] btn_edge;
  logic [8:0] lines_sum;
  logic [7:0] interval;
  logic       drop_tick;

  assign btn_now   = {btn_rotate, btn_right, btn_left};
  assign btn_edge  = btn_now & ~btn_q;
  assign lines_sum = {1'b0, lines_q} + {6'd0, rows_cleared};

`ifdef LEVEL_SPEEDUP_EN
  logic [7:0] interval_q, interval_d;
  logic [1:0] level;

  assign level      = (lines_q[7:2] > 6'd3) ? 2'd3 : lines_q[3:2];
  // Latched at GEN so the speed never changes under a falling piece.
  assign interval_d = (state_q == ST_GEN) ? (DROP_W >> level) : interval_q;
  assign interval   = interval_q;

  always_ff @(posedge clka) begin
    if (restart) interval_q <= DROP_W;
    else         interval_q <= interval_d;
  end
`else
  assign interval = DROP_W;
`endif

  assign drop_tick = (grav_q == interval - 8'd1);

  // Strobes are the registered action of the current state, so they show up
  // one cycle after the state that issued them.
  always_comb begin
    state_d    = state_q;
    move_d     = MV_NONE;
    piece_we_d = 1'b0;
    board_we_d = 1'b0;
    lines_d    = lines_q;
    grav_d     = grav_q;
    pend_d     = pend_q;

    case (state_q)
      ST_NEWBOARD: begin
        board_we_d = 1'b1;
        state_d    = ST_GEN;
      end
      ST_GEN: begin
        piece_we_d = 1'b1;
        grav_d     = '0;
        pend_d     = '0;
        state_d    = error_out ? ST_GAMEOVER : ST_MOVE;
      end
      ST_MOVE: begin
        pend_d = pend_q | btn_edge;
        grav_d = drop_tick ? 8'd0 : grav_q + 8'd1;
        if (touched) begin
          state_d = ST_LAND;
          pend_d  = '0;
        end else if (drop_tick) begin
          piece_we_d = 1'b1;
        end else if (pend_q[0]) begin
          move_d     = MV_LEFT;
          piece_we_d = 1'b1;
          pend_d[0]  = btn_edge[0];
        end else if (pend_q[1]) begin
          move_d     = MV_RIGHT;
          piece_we_d = 1'b1;
          pend_d[1]  = btn_edge[1];
        end else if (pend_q[2]) begin
          move_d     = MV_ROTATE;
          piece_we_d = 1'b1;
          pend_d[2]  = btn_edge[2];
        end
      end
      ST_LAND: begin
        board_we_d = 1'b1;
        state_d    = ST_CLEAR;
      end
      ST_CLEAR: begin
        board_we_d = 1'b1;
        if (phase_q == 4'd0) lines_d = lines_sum[8] ? 8'hFF : lines_sum[7:0];
        if (phase_q == CLEAR_LAST) state_d = ST_GEN;
      end
      ST_GAMEOVER: begin
        board_we_d = (phase_q == 4'd0);
      end
      default: begin
        state_d = ST_NEWBOARD;
      end
    endcase

    // Cycles spent in the current state, saturating; zero on the entry cycle.
    if (state_d != state_q)    phase_d = 4'd0;
    else if (phase_q == 4'hF)  phase_d = phase_q;
    else                       phase_d = phase_q + 4'd1;
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      state_q    <= ST_NEWBOARD;
      move_q     <= MV_NONE;
      piece_we_q <= 1'b0;
      board_we_q <= 1'b0;
      lines_q    <= 8'd0;
      grav_q     <= 8'd0;
      pend_q     <= 3'd0;
      btn_q      <= 3'd0;
      phase_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      move_q     <= move_d;
      piece_we_q <= piece_we_d;
      board_we_q <= board_we_d;
      lines_q    <= lines_d;
      grav_q     <= grav_d;
      pend_q     <= pend_d;
      btn_q      <= btn_now;
      phase_q    <= phase_d;
    end
  end

  assign state    = state_q;
  assign move     = move_q;
  assign piece_we = piece_we_q;
  assign board_we = board_we_q;
  assign lines    = lines_q;

endmodule
`default_nettype wire

// File: tb/tb_tetris_ctrl.sv
`default_nettype none
// tb_tetris_ctrl : directed bench for tetris_ctrl (DROP_TICKS=16, CLEAR_CYCLES=2).
module tb_tetris_ctrl;

`ifdef LEVEL_SPEEDUP_EN
  localparam int LVL2_IVL = 4;
`else
  localparam int LVL2_IVL = 16;
`endif

  logic       clka = 1'b0;
  logic       restart = 1'b1;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_rotate = 1'b0;
  logic       touched = 1'b0;
  logic       error_out = 1'b0;
  logic [2:0] rows_cleared = 3'd0;
  logic [2:0] state;
  logic [1:0] move;
  logic       piece_we;
  logic       board_we;
  logic [7:0] lines;

  int n_cmp = 0;
  int n_bad = 0;

  tetris_ctrl #(.DROP_TICKS(16), .CLEAR_CYCLES(2)) dut (
    .clka        (clka),
    .restart     (restart),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_rotate  (btn_rotate),
    .touched     (touched),
    .error_out   (error_out),
    .rows_cleared(rows_cleared),
    .state       (state),
    .move        (move),
    .piece_we    (piece_we),
    .board_we    (board_we),
    .lines       (lines)
  );

  always #5 clka = ~clka;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clocks; outputs are then sampled 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clka);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(3);
    check_eq("rst_state", int'(state), 4);
    check_eq("rst_move", int'(move), 3);
    check_eq("rst_pwe", int'(piece_we), 0);
    check_eq("rst_bwe", int'(board_we), 0);
    check_eq("rst_lines", int'(lines), 0);

    // Release: NEWBOARD, GEN, MOVE; strobes trail their state by one cycle.
    restart = 1'b0;
    check_eq("c0_state", int'(state), 4);
    step(1);
    check_eq("c1_state", int'(state), 0);
    check_eq("c1_bwe", int'(board_we), 1);
    check_eq("c1_pwe", int'(piece_we), 0);
    step(1);
    check_eq("c2_state", int'(state), 1);
    check_eq("c2_pwe", int'(piece_we), 1);
    check_eq("c2_bwe", int'(board_we), 0);
    step(15);
    check_eq("grav_early_pwe", int'(piece_we), 0);
    step(1);
    check_eq("grav_pwe", int'(piece_we), 1);
    check_eq("grav_move", int'(move), 3);

    // Left and rotate pressed together, then held.
    btn_left = 1'b1;
    btn_rotate = 1'b1;
    step(1);
    check_eq("btn_lat_pwe", int'(piece_we), 0);
    step(1);
    check_eq("btn_left_move", int'(move), 0);
    check_eq("btn_left_pwe", int'(piece_we), 1);
    step(1);
    check_eq("btn_rot_move", int'(move), 2);
    check_eq("btn_rot_pwe", int'(piece_we), 1);
    step(1);
    check_eq("btn_held_pwe0", int'(piece_we), 0);
    step(1);
    check_eq("btn_held_pwe1", int'(piece_we), 0);
    btn_left = 1'b0;
    btn_rotate = 1'b0;

    // Right edge whose pending flag meets the gravity-drop decision.
    step(9);
    btn_right = 1'b1;
    step(1);
    check_eq("coll_pre_pwe", int'(piece_we), 0);
    step(1);
    check_eq("coll_drop_move", int'(move), 3);
    check_eq("coll_drop_pwe", int'(piece_we), 1);
    step(1);
    check_eq("coll_right_move", int'(move), 1);
    check_eq("coll_right_pwe", int'(piece_we), 1);
    step(1);
    check_eq("coll_post_pwe", int'(piece_we), 0);
    btn_right = 1'b0;

    // Landing with three rows cleared.
    touched = 1'b1;
    rows_cleared = 3'd3;
    step(1);
    check_eq("land_state", int'(state), 2);
    check_eq("land_pwe", int'(piece_we), 0);
    touched = 1'b0;
    step(1);
    check_eq("clr1_state", int'(state), 3);
    check_eq("clr1_bwe", int'(board_we), 1);
    step(1);
    check_eq("clr2_state", int'(state), 3);
    check_eq("clr2_bwe", int'(board_we), 1);
    check_eq("clr2_lines", int'(lines), 3);
    rows_cleared = 3'd4;
    step(1);
    check_eq("clr_gen_state", int'(state), 0);
    check_eq("clr_gen_bwe", int'(board_we), 1);
    check_eq("clr_gen_lines", int'(lines), 3);
    rows_cleared = 3'd0;
    step(1);
    check_eq("clr_move_state", int'(state), 1);
    check_eq("clr_move_pwe", int'(piece_we), 1);
    check_eq("clr_move_bwe", int'(board_we), 0);

    // Spawn collision -> GAMEOVER.
    touched = 1'b1;
    step(1);
    touched = 1'b0;
    step(3);
    check_eq("go_gen_state", int'(state), 0);
    error_out = 1'b1;
    step(1);
    error_out = 1'b0;
    check_eq("go_state", int'(state), 5);
    check_eq("go_gen_pwe", int'(piece_we), 1);
    check_eq("go_entry_bwe0", int'(board_we), 0);
    step(1);
    check_eq("go_bwe", int'(board_we), 1);
    check_eq("go_pwe", int'(piece_we), 0);
    for (int i = 0; i < 100; i++) begin
      btn_left = i[0];
      btn_right = i[1];
      btn_rotate = i[0];
      step(1);
      check_eq("go_hold", int'({state, move, piece_we, board_we}), 92);
    end
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_rotate = 1'b0;
    check_eq("go_lines", int'(lines), 3);

    restart = 1'b1;
    step(1);
    check_eq("rst_go_state", int'(state), 4);
    check_eq("rst_go_lines", int'(lines), 0);
    check_eq("rst_go_bwe", int'(board_we), 0);
    restart = 1'b0;
    step(7);
    check_eq("mid_pre_state", int'(state), 1);

    // Reset in the middle of MOVE, gravity timing restarts from zero.
    restart = 1'b1;
    step(1);
    check_eq("mid_rst_state", int'(state), 4);
    check_eq("mid_rst_pwe", int'(piece_we), 0);
    restart = 1'b0;
    step(2);
    check_eq("mid_move_state", int'(state), 1);
    step(15);
    check_eq("mid_grav_early", int'(piece_we), 0);
    step(1);
    check_eq("mid_grav_pwe", int'(piece_we), 1);

    // Repeated four-row clears: level speed-up at 8 lines, saturation at 255.
    rows_cleared = 3'd4;
    for (int k = 1; k <= 64; k++) begin
      touched = 1'b1;
      step(1);
      touched = 1'b0;
      step(4);
      if (k == 2) begin
        check_eq("lvl_lines", int'(lines), 8);
        check_eq("lvl_state", int'(state), 1);
        step(LVL2_IVL - 1);
        check_eq("lvl_early_pwe", int'(piece_we), 0);
        step(1);
        check_eq("lvl_drop_pwe", int'(piece_we), 1);
        check_eq("lvl_drop_move", int'(move), 3);
      end
      if (k == 63) check_eq("sat_252", int'(lines), 252);
      if (k == 64) check_eq("sat_255", int'(lines), 255);
    end
    rows_cleared = 3'd0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
